// File: rtl/pci_burst_initiator_if.sv
// Shared-bus signal bundle between a burst initiator (master) and the bus/target side (slave).
interface pci_burst_initiator_if #(
    parameter int DATA_W = 32
);
    logic              request;
    logic              grant;
    logic              frame;
    logic              irdy;
    logic              trdy;
    logic [DATA_W-1:0] ad;

    modport master (output request, frame, irdy, ad, input grant, trdy);
    modport slave  (input request, frame, irdy, ad, output grant, trdy);
endinterface

// File: rtl/pci_burst_initiator.sv
// Write-burst bus initiator: request/grant handshake, frame/irdy beat streaming, done/abort report.
// Optional grant-wait abort is enabled by defining GNT_TIMEOUT_EN.
module pci_burst_initiator #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    pci_burst_initiator_if.master bus,
    output logic              done,
    output logic [LEN_W-1:0]  beats_done,
    output logic              aborted
);

    typedef enum logic [2:0] {IDLE, REQ, XFER, LAST, TURN} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             lost;
    logic             go;
    logic             beat;
    logic             timeout;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign go   = bus.grant && wdata_valid;
    assign beat = (state == XFER || state == LAST) && wdata_valid && !bus.trdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt   <= '0;
            lost  <= 1'b0;
        end else if (state == IDLE) begin
            cnt  <= '0;
            lost <= 1'b0;
            if (cmd_valid) len_q <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
        end else begin
            if (beat && cnt != len_q) cnt <= cnt + LEN_W'(1);
            if (state == XFER && !bus.grant) lost <= 1'b1;
        end
    end

`ifdef GNT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       to_cnt <= '0;
        else if (state != REQ)            to_cnt <= '0;
        else if (!bus.grant)              to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout = (state == REQ) && !bus.grant && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // A grant loss (now or earlier, sticky) lets the beat in flight finish, then allows one LAST beat.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (cmd_valid) state_nx = REQ;
            REQ: begin
                if (go)           state_nx = (len_q == LEN_W'(1)) ? LAST : XFER;
                else if (timeout) state_nx = TURN;
            end
            XFER: if (beat && ((cnt + LEN_W'(1) == len_q - LEN_W'(1)) || lost || !bus.grant))
                      state_nx = LAST;
            LAST: if (beat) state_nx = TURN;
            TURN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        bus.request = 1'b0;
        bus.frame   = 1'b1;
        bus.irdy    = 1'b1;
        bus.ad      = '0;
        done        = 1'b0;
        beats_done  = '0;
        aborted     = 1'b0;
        unique case (state)
            IDLE: cmd_ready = rst_n;
            REQ: begin
                bus.request = 1'b1;
                bus.frame   = !go;
                bus.irdy    = !go;
            end
            XFER: begin
                bus.frame   = 1'b0;
                bus.irdy    = !wdata_valid;
                bus.ad      = wdata;
                wdata_ready = beat;
            end
            LAST: begin
                bus.irdy    = !wdata_valid;
                bus.ad      = wdata;
                wdata_ready = beat;
            end
            TURN: begin
                done       = 1'b1;
                beats_done = cnt;
                aborted    = (cnt != len_q);
            end
            default: ;
        endcase
    end

endmodule
